// File: rtl/mrc_cmd_driver.sv
// mrc_cmd_driver
// Initiator for one MRC instance. Takes a command (op, a, b) from a host
// over a valid/ready handshake, walks the MRC through start, the x/y
// operand-request handshake and the load pulses, waits for ready, then
// returns Result/error on a response handshake held until acknowledged.
// Every wait state is guarded by a timeout that aborts with an error.
//
// Ports
//   clk, reset (async, active-low)
//   host side : cmd_valid/cmd_ready, cmd_op, cmd_a, cmd_b,
//               rsp_valid/rsp_ack, rsp_result, rsp_error, rsp_timeout
//   MRC side  : start, load, Data, op (outputs); ready, Result, x, y, error (inputs)
module mrc_cmd_driver #(
    parameter int WORD_LENGTH    = 16,
    parameter int START_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_op,
    input  logic [WORD_LENGTH-1:0]   cmd_a,
    input  logic [WORD_LENGTH-1:0]   cmd_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ack,
    output logic [2*WORD_LENGTH-1:0] rsp_result,
    output logic                     rsp_error,
    output logic                     rsp_timeout,
    output logic                     start,
    output logic                     load,
    output logic [WORD_LENGTH-1:0]   Data,
    output logic                     op,
    input  logic                     ready,
    input  logic [2*WORD_LENGTH-1:0] Result,
    input  logic                     x,
    input  logic                     y,
    input  logic                     error
);

    // Wait counter runs 0 .. TIMEOUT_CYCLES-1; the last value triggers the abort.
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    START_LAST = 4'(START_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_X,
        S_LOAD_A,
        S_WAIT_Y,
        S_LOAD_B,
        S_WAIT_RDY,
        S_RESP
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [WORD_LENGTH-1:0] a_reg;
    logic [WORD_LENGTH-1:0] b_reg;
    logic [3:0]             start_cnt;
    logic [TW-1:0]          wait_cnt;
    logic                   load_arm;

    // Combinational strobes consumed by the datapath register block.
    logic accept;
    logic present_a;
    logic present_b;
    logic capture;
    logic expire;
    logic in_wait;
    logic wait_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        present_a = 1'b0;
        present_b = 1'b0;
        capture   = 1'b0;
        expire    = 1'b0;
        cmd_ready = 1'b0;
        start     = 1'b0;
        load      = 1'b0;
        rsp_valid = 1'b0;
        in_wait   = 1'b0;
        wait_last = (wait_cnt == WAIT_LAST);

        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                start = 1'b1;
                if (start_cnt == START_LAST) begin
                    // Present A as soon as start drops so it is settled well
                    // before the load pulse.
                    present_a = 1'b1;
                    state_nxt = S_WAIT_X;
                end
            end
            S_WAIT_X: begin
                in_wait = 1'b1;
                if (x) begin
                    present_a = 1'b1;
                    state_nxt = S_LOAD_A;
                end else if (wait_last) begin
                    expire    = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_LOAD_A: begin
                load      = 1'b1;
                state_nxt = S_WAIT_Y;
            end
            S_WAIT_Y: begin
                in_wait = 1'b1;
                // y has priority: a two-operand op must always receive B.
                if (y) begin
                    present_b = 1'b1;
                    state_nxt = S_LOAD_B;
                end else if (ready) begin
                    capture   = 1'b1;
                    state_nxt = S_RESP;
                end else if (wait_last) begin
                    expire    = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_LOAD_B: begin
                // First cycle only settles Data=B; the pulse follows on the second.
                load = load_arm;
                if (load_arm) begin
                    state_nxt = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                in_wait = 1'b1;
                if (ready) begin
                    capture   = 1'b1;
                    state_nxt = S_RESP;
                end else if (wait_last) begin
                    expire    = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg       <= '0;
            b_reg       <= '0;
            op          <= 1'b0;
            Data        <= '0;
            start_cnt   <= '0;
            wait_cnt    <= '0;
            load_arm    <= 1'b0;
            rsp_result  <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (accept) begin
                a_reg       <= cmd_a;
                b_reg       <= cmd_b;
                op          <= cmd_op;
                rsp_error   <= 1'b0;
                rsp_timeout <= 1'b0;
            end

            start_cnt <= (state == S_START) ? start_cnt + 4'd1 : 4'd0;

            // Any transition out of (or into) a wait state restarts the count.
            if (in_wait && (state_nxt == state)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            load_arm <= (state == S_LOAD_B);

            if (present_a) begin
                Data <= a_reg;
            end else if (present_b) begin
                Data <= b_reg;
            end

            if (capture) begin
                rsp_result <= Result;
                rsp_error  <= error;
            end else if (expire) begin
                rsp_result  <= '0;
                rsp_error   <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mrc_cmd_driver.sv
module tb_mrc_cmd_driver;

    localparam int WL = 16;
    localparam int SC = 4;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_op = 1'b0;
    logic [WL-1:0] cmd_a = '0;
    logic [WL-1:0] cmd_b = '0;
    logic          rsp_valid;
    logic          rsp_ack = 1'b0;
    logic [2*WL-1:0] rsp_result;
    logic          rsp_error;
    logic          rsp_timeout;
    logic          start;
    logic          load;
    logic [WL-1:0] Data;
    logic          op;
    logic          ready;
    logic [2*WL-1:0] Result;
    logic          x;
    logic          y;
    logic          error;

    always #5 clk = ~clk;

    mrc_cmd_driver #(
        .WORD_LENGTH(WL),
        .START_CYCLES(SC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_result(rsp_result),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .start(start), .load(load), .Data(Data), .op(op),
        .ready(ready), .Result(Result), .x(x), .y(y), .error(error)
    );

    // MRC model. mode 0: multiply, 1: single operand (Result=5),
    // 2: multiply with error when b==0, 3: never requests y.
    int            mode = 0;
    int            phase;
    int            m_cnt;
    logic [WL-1:0] m_a;
    logic [WL-1:0] m_b;

    always @(posedge clk) begin
        if (!reset) begin
            phase <= 0; m_cnt <= 0; x <= 1'b0; y <= 1'b0;
            ready <= 1'b0; error <= 1'b0; Result <= '0; m_a <= '0; m_b <= '0;
        end else begin
            case (phase)
                0: if (start) phase <= 1;
                1: if (!start) begin x <= 1'b1; phase <= 2; end
                2: if (load) begin
                    x   <= 1'b0;
                    m_a <= Data;
                    if (mode == 1) begin
                        ready <= 1'b1; Result <= 32'd5; error <= 1'b0; phase <= 5;
                    end else if (mode == 3) begin
                        phase <= 6;
                    end else begin
                        y <= 1'b1; phase <= 3;
                    end
                end
                3: if (load) begin y <= 1'b0; m_b <= Data; m_cnt <= 0; phase <= 4; end
                4: begin
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == 7) begin
                        ready  <= 1'b1;
                        Result <= 32'(m_a) * 32'(m_b);
                        error  <= (mode == 2) && (m_b == '0);
                        phase  <= 5;
                    end
                end
                default: if (start) begin ready <= 1'b0; error <= 1'b0; phase <= 1; end
            endcase
        end
    end

    // Pin monitor, sampled away from the active edge.
    int            n_load = 0;
    int            n_start_rise = 0;
    int            start_run = 0;
    int            last_start_len = 0;
    int            overlap = 0;
    int            setup_err = 0;
    int            n_saw_b = 0;
    logic [WL-1:0] ld_prev = '0;
    logic [WL-1:0] ld_last = '0;
    logic [WL-1:0] data_prev = '0;
    logic          start_prev = 1'b0;
    logic          watch_en = 1'b0;
    logic [WL-1:0] watch_b = '0;

    always @(negedge clk) begin
        if (load && start) overlap++;
        if (load && (Data != data_prev)) setup_err++;
        if (load) begin n_load++; ld_prev = ld_last; ld_last = Data; end
        if (start && !start_prev) n_start_rise++;
        if (start) start_run++;
        else if (start_run != 0) begin last_start_len = start_run; start_run = 0; end
        if (watch_en && (Data == watch_b)) n_saw_b++;
        data_prev  = Data;
        start_prev = start;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic o, input logic [WL-1:0] a, input logic [WL-1:0] b);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        chk("send_rdy", cmd_ready, 1);
        cmd_op = o; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
        chk("rsp_seen", rsp_valid, 1);
    endtask

    task automatic finish_rsp();
        repeat (3) @(negedge clk);
        chk("rsp_hold", rsp_valid, 1);
        rsp_ack = 1'b1;
        @(negedge clk);
        rsp_ack = 1'b0;
        chk("rsp_clr", rsp_valid, 0);
        chk("rdy_back", cmd_ready, 1);
    endtask

    initial begin
        int sl, ss, sb, n, len;

        // Reset state
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_start", start, 0);
        chk("rst_load", load, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_data", Data, 0);
        chk("rst_op", op, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_err_to", {rsp_error, rsp_timeout}, 0);

        // Multiply path: 25*6
        mode = 0; sl = n_load; ss = n_start_rise;
        send(1'b1, 16'd25, 16'd6);
        wait_rsp();
        chk("mul_result", rsp_result, 150);
        chk("mul_error", rsp_error, 0);
        chk("mul_timeout", rsp_timeout, 0);
        chk("mul_op", op, 1);
        chk("mul_loads", n_load - sl, 2);
        chk("mul_starts", n_start_rise - ss, 1);
        chk("mul_ld_a", ld_prev, 25);
        chk("mul_ld_b", ld_last, 6);
        chk("mul_start_len", last_start_len, SC);
        finish_rsp();

        // Single-operand op: B must never appear on Data
        mode = 1; sl = n_load; sb = n_saw_b; watch_b = 16'd77; watch_en = 1'b1;
        send(1'b0, 16'd25, 16'd77);
        wait_rsp();
        chk("single_result", rsp_result, 5);
        chk("single_loads", n_load - sl, 1);
        chk("single_no_b", n_saw_b - sb, 0);
        chk("single_op", op, 0);
        watch_en = 1'b0;
        finish_rsp();

        // Error pass-through: b=0
        mode = 2;
        send(1'b1, 16'd9, 16'd0);
        wait_rsp();
        chk("err_error", rsp_error, 1);
        chk("err_timeout", rsp_timeout, 0);
        chk("err_result", rsp_result, 0);
        finish_rsp();

        // Timeout in WAIT_Y. WAIT_Y is entered the cycle after the load pulse,
        // so the flag shows TO cycles after entry = TO+1 cycles after the load.
        mode = 3;
        send(1'b1, 16'd5, 16'd5);
        n = 0;
        while (!load && n < 100) begin @(negedge clk); n++; end
        chk("to_load", load, 1);
        n = 0;
        while (!rsp_timeout && n < 60) begin @(negedge clk); n++; end
        chk("to_latency", n, TO + 1);
        chk("to_flag", rsp_timeout, 1);
        chk("to_error", rsp_error, 1);
        chk("to_result", rsp_result, 0);
        chk("to_valid", rsp_valid, 1);
        finish_rsp();
        mode = 0;
        send(1'b1, 16'd2, 16'd3);
        chk("to_clr_flags", {rsp_error, rsp_timeout}, 0);
        wait_rsp();
        chk("after_to_result", rsp_result, 6);
        finish_rsp();

        // Reset during WAIT_RDY
        mode = 0; sl = n_load;
        send(1'b1, 16'd7, 16'd9);
        n = 0;
        while ((n_load - sl) < 2 && n < 100) begin @(negedge clk); n++; end
        chk("mid_loads", n_load - sl, 2);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_start", start, 0);
        chk("mid_load", load, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_data", Data, 0);
        chk("mid_op", op, 0);
        chk("mid_result", rsp_result, 0);
        chk("mid_err_to", {rsp_error, rsp_timeout}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready", cmd_ready, 1);
        chk("mid_rel_valid", rsp_valid, 0);
        send(1'b1, 16'd3, 16'd4);
        wait_rsp();
        chk("mid_new_result", rsp_result, 12);
        finish_rsp();

        // Back-to-back with cmd_valid held and rsp_ack tied high
        @(negedge clk);
        cmd_op = 1'b1; cmd_a = 16'd5; cmd_b = 16'd7; cmd_valid = 1'b1; rsp_ack = 1'b1;
        @(negedge clk);
        wait_rsp();
        chk("b2b_result1", rsp_result, 35);
        chk("b2b_start_len1", last_start_len, SC);
        cmd_a = 16'd6; cmd_b = 16'd8;
        @(negedge clk);
        chk("b2b_idle", cmd_ready, 1);
        @(negedge clk);
        chk("b2b_start", start, 1);
        cmd_valid = 1'b0;
        len = 0;
        while (start && len < 20) begin len++; @(negedge clk); end
        chk("b2b_start_len2", len, SC);
        wait_rsp();
        chk("b2b_result2", rsp_result, 48);
        @(negedge clk);
        rsp_ack = 1'b0;
        chk("b2b_done", cmd_ready, 1);

        // Pin-level invariants across the whole run
        chk("no_load_start_overlap", overlap, 0);
        chk("data_setup", setup_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mrc_cmd_driver.md
Name: mrc_cmd_driver

Overview:
- Initiator side of the MRC operand interface.
- Accepts a command (op plus two operands) from a host over a valid/ready handshake.
- Sequences the MRC start/load/Data/op pins through the x/y operand-request handshake and waits for ready.
- Captures Result and error, and returns them on a held response handshake.
- Sits between the system controller and one MRC instance, replacing hand-driven stimulus.

Parameters:
- WORD_LENGTH, 16, operand width; Result width is 2*WORD_LENGTH.
- START_CYCLES, 1, number of cycles the start pin is held high (range 1..15).
- TIMEOUT_CYCLES, 1023, maximum cycles spent in any wait state before aborting (must be ≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  host command present.
- cmd_ready  out  1  driver idle and able to accept a command.
- cmd_op  in  1  operation select, forwarded to MRC op.
- cmd_a  in  WORD_LENGTH  first operand.
- cmd_b  in  WORD_LENGTH  second operand.
- rsp_valid  out  1  response available; held until acknowledged.
- rsp_ack  in  1  host consumes response.
- rsp_result  out  2*WORD_LENGTH  captured MRC Result.
- rsp_error  out  1  captured MRC error.
- rsp_timeout  out  1  operation aborted by timeout.
- start  out  1  to MRC start.
- load  out  1  to MRC load.
- Data  out  WORD_LENGTH  to MRC Data.
- op  out  1  to MRC op.
- ready  in  1  from MRC, result valid.
- Result  in  2*WORD_LENGTH  from MRC.
- x  in  1  from MRC, first operand requested.
- y  in  1  from MRC, second operand requested.
- error  in  1  from MRC, operation error.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - start, load, rsp_valid, rsp_error, rsp_timeout = 0.
  - Data = 0, op = 0, rsp_result = 0.
  - cmd_ready = 1 after reset release.
  - Internal operand registers and counters cleared.
- Reset mid-operation aborts immediately to IDLE. No response is generated.
- States:
  - IDLE: cmd_ready=1. When cmd_valid=1, latch cmd_op into op and latch cmd_a and cmd_b internally, then go to START. cmd_ready=0 in every other state.
  - START: start=1 for exactly START_CYCLES cycles, then start=0 and go to WAIT_X.
  - WAIT_X: when x=1, drive Data=A and go to LOAD_A.
  - LOAD_A: load=1 for exactly one cycle with Data=A, then go to WAIT_Y. Data holds A until it is next changed.
  - WAIT_Y:
    - If y=1, drive Data=B and go to LOAD_B.
    - If ready=1 without y (single-operand op), capture and go to RESP; B is never presented.
    - If ready and y are both 1, y wins.
  - LOAD_B: load=1 for one cycle with Data=B, then go to WAIT_RDY.
  - WAIT_RDY: on the first cycle with ready=1, register Result into rsp_result and error into rsp_error, then go to RESP.
  - RESP: rsp_valid=1, outputs held stable. On rsp_ack=1, clear rsp_valid and go to IDLE. cmd_ready returns to 1 on the next cycle.
- Data setup: Data is stable at least one cycle before and during every load pulse.
- load and start are never high in the same cycle.
- Timeout:
  - A wait counter clears on entry to WAIT_X, WAIT_Y and WAIT_RDY and increments each cycle in those states.
  - When the count reaches TIMEOUT_CYCLES: rsp_timeout=1, rsp_error=1, rsp_result=0, go to RESP.
  - rsp_timeout and rsp_error clear when the next command is accepted.
- A cmd_valid asserted while busy is ignored (cmd_ready=0); the host must hold it.
- Latency from acceptance to start high is 1 cycle.
- Minimum total latency is START_CYCLES + 4 + (MRC compute time).
- rsp_ack outside RESP has no effect.

Test Plan:
- Multiply path: bench MRC model (x after start, y after first load, ready 8 cycles later, Result=a*b). cmd_op=1, a=25, b=6 → one start pulse, load with Data=25 then load with Data=6, rsp_result=150, rsp_error=0, rsp_valid held until rsp_ack.
- Single-operand op: model raises ready after first load with Result=5 for a=25 → no second load occurs, rsp_result=5, Data never equals b.
- Error pass-through: model returns error=1 with b=0 → rsp_error=1, rsp_timeout=0.
- Timeout: TIMEOUT_CYCLES=20, model never raises y → rsp_timeout=1 and rsp_error=1 exactly 20 cycles after entry to WAIT_Y; next command clears both flags.
- Reset mid-op: reset=0 during WAIT_RDY → all outputs return to reset values asynchronously, no rsp_valid; after release, a new command (a=3, b=4) completes with rsp_result=12.
- Back-to-back: cmd_valid held high and rsp_ack tied high → second command accepted the cycle after RESP exits; START_CYCLES=4 yields a 4-cycle start pulse on each command.
